// File: rtl/key_press_emulator.sv
// Key-press stimulus source: press bounce, clean hold, release bounce, settled release.
// Optional KEY_EMU_LFSR_EN selects pseudo-random bounce segment lengths from a 16-bit LFSR.
module key_press_emulator #(
    parameter int unsigned BOUNCE_WIN   = 25000,
    parameter int unsigned GLITCH_BITS  = 8,
    parameter int unsigned HOLD_W       = 24,
    parameter logic        ACTIVE_LEVEL = 1'b1
) (
    input  logic              Sys_CLK,
    input  logic              Rst_n,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              busy,
    output logic              done,
    output logic              Key_out
);

    localparam int unsigned       WIN_W    = $clog2(BOUNCE_WIN);
    localparam int unsigned       SEG_W    = GLITCH_BITS + 1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(BOUNCE_WIN - 1);
    localparam logic [WIN_W-1:0]  WIN_ONE  = WIN_W'(1);
    localparam logic [SEG_W-1:0]  SEG_ONE  = SEG_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic              KEY_ON   = ACTIVE_LEVEL;
    localparam logic              KEY_OFF  = ~ACTIVE_LEVEL;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        RELEASE_BOUNCE,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                key_q, key_d;
    logic [SEG_W-1:0]    seg_len;

`ifdef KEY_EMU_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        seg_load;

    assign seg_len = {1'b0, lfsr_q[GLITCH_BITS-1:0]} + SEG_ONE;

    // A segment load happens on every bounce-window entry and on every in-window expiry.
    always_comb begin
        seg_load = ((state_d == PRESS_BOUNCE) || (state_d == RELEASE_BOUNCE)) &&
                   ((state_d != state_q) || (seg_q == SEG_ONE));
        lfsr_d = lfsr_q;
        if (seg_load) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge Sys_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    localparam logic [SEG_W-1:0] SEG_FIXED = SEG_W'(1 << (GLITCH_BITS - 1));

    assign seg_len = SEG_FIXED;
`endif

    always_ff @(posedge Sys_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            seg_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            key_q   <= KEY_OFF;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            seg_q   <= seg_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        seg_d   = seg_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PRESS_BOUNCE;
                    hold_d  = hold_cycles;
                    win_d   = '0;
                    seg_d   = seg_len;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                if (win_q != WIN_LAST) begin
                    win_d = win_q + WIN_ONE;
                    seg_d = (seg_q == SEG_ONE) ? seg_len : (seg_q - SEG_ONE);
                end else if (state_q == RELEASE_BOUNCE) begin
                    state_d = DONE;
                end else if (hold_q == '0) begin
                    state_d = RELEASE_BOUNCE;
                    win_d   = '0;
                    seg_d   = seg_len;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                hold_d = hold_q - HOLD_ONE;
                if (hold_q == HOLD_ONE) begin
                    state_d = RELEASE_BOUNCE;
                    win_d   = '0;
                    seg_d   = seg_len;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed for the upcoming cycle so every port comes straight from a flop.
    always_comb begin
        busy_d = (state_d == PRESS_BOUNCE) || (state_d == HOLD) || (state_d == RELEASE_BOUNCE);
        done_d = (state_d == DONE);
        key_d  = KEY_OFF;
        case (state_d)
            PRESS_BOUNCE: begin
                if ((state_q != PRESS_BOUNCE) || (win_d == WIN_LAST)) begin
                    key_d = KEY_ON;
                end else if (seg_q == SEG_ONE) begin
                    key_d = ~key_q;
                end else begin
                    key_d = key_q;
                end
            end
            HOLD: key_d = KEY_ON;
            RELEASE_BOUNCE: begin
                if ((state_q != RELEASE_BOUNCE) || (win_d == WIN_LAST)) begin
                    key_d = KEY_OFF;
                end else if (seg_q == SEG_ONE) begin
                    key_d = ~key_q;
                end else begin
                    key_d = key_q;
                end
            end
            default: key_d = KEY_OFF;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Key_out = key_q;

endmodule
